am2910_sequencer: RTL and testbench
===================================

// Module: am2910_sequencer
// PURPOSE
//  Microprogram sequencer (Am2910 instruction set) generating the next microword address each cycle.
//  It sits upstream of the Am2901 ALU slices: its yout addresses the control store, which supplies the Am2901 control fields.
//  Holds a microPC, a loop/count register R and a LIFO return stack. Condition input comes from the Am2901 flags (fzero, cout, f3, ovr) via a mux.
// PARAMETERS
//  AW           12  address width of din, yout, uPC, R and stack entries
//  STACK_DEPTH   5  number of stack entries (SP range 0..STACK_DEPTH)
// PORTS
//  clock   in   1   system clock; all state updates on posedge
//  reset   in   1   synchronous, active-high reset
//  instr   in   4   sequencer opcode I[3:0] (table below)
//  din     in   AW  direct/branch address from pipeline, map PROM or vector
//  cc_n    in   1   condition code, active low
//  ccen_n  in   1   condition enable, active low; 1 = force pass
//  rld_n   in   1   0 = load R from din this cycle, for any opcode
//  ci      in   1   incrementer carry: uPC <= yout + ci
//  yout    out  AW  next microaddress (combinational from state/instr/din)
//  full_n  out  1   0 when SP == STACK_DEPTH
//  pl_n    out  1   0 selects pipeline register as din source
//  map_n   out  1   0 selects map PROM (JMAP only)
//  vect_n  out  1   0 selects vector (CJV only)
// BEHAVIOUR
//  pass = ccen_n | ~cc_n. TOS = stack[SP-1], reads 0 when SP==0. Rnz = (R != 0).
//  Opcodes (yout ; state effect); pl_n=0 for all except 2 (map_n=0) and 6 (vect_n=0):
//   0 JZ   0 ; SP<=0              1 CJS  pass?D:uPC ; pass: push uPC
//   2 JMAP D                       3 CJP  pass?D:uPC
//   4 PUSH uPC ; push uPC, pass: R<=D
//   5 JSRP pass?D:R ; push uPC     6 CJV  pass?D:uPC
//   7 JRP  pass?D:R                8 RFCT Rnz?TOS:uPC ; Rnz: R--, else pop
//   9 RPCT Rnz?D:uPC ; Rnz: R--    10 CRTN pass?TOS:uPC ; pass: pop
//   11 CJPP pass?D:uPC ; pass: pop 12 LDCT uPC ; R<=D
//   13 LOOP pass?uPC:TOS ; pass: pop   14 CONT uPC
//   15 TWB Rnz: pass?uPC:TOS, R--, pass: pop; R==0: pass?uPC:D, pop
//  Every cycle (not reset): uPC <= yout + ci, truncated to AW bits (0xFFF+1 wraps to 0).
//  Latency: yout valid combinationally in the cycle instr is presented; R, SP, stack and uPC update on the following posedge.
//  Push writes the pre-edge uPC (the return address) to stack[SP] and sets SP<=SP+1.
//  Push when SP==STACK_DEPTH: overwrites stack[STACK_DEPTH-1], SP holds; full_n stays 0.
//  Pop when SP==0: no-op; SP stays 0.
//  R decrement: 12-bit, applied only when Rnz, so R never wraps.
//  rld_n==0 overrides any R update from the opcode (load D wins over decrement and over PUSH/LDCT).
//  Rnz and pass are sampled from pre-edge values; yout and the state update use the same cycle's decision.
//  Reset (synchronous): uPC<=0, R<=0, SP<=0, all stack entries<=0; yout forced to 0 while reset is high.
//  full_n=1 and pl_n=0, map_n=1, vect_n=1 while reset is high.
//  Reset asserted mid-loop or mid-subroutine discards all state; the first cycle after reset starts at uPC=0.
// TESTING
//  reset, then CONT x3 with ci=1 -> yout 0,1,2; uPC=3.
//  CJS D=0x100 pass at uPC=0x010 -> yout=0x100; then CRTN pass -> yout=0x010, SP back to 0.
//  CJP D=0x200 with ccen_n=0, cc_n=1 (fail) -> yout=uPC, no jump; with ccen_n=1 -> yout=0x200.
//  Loop: LDCT D=2, then PUSH at 0x020, then RFCT x3 -> yout=TOS(0x021) twice with R 2->1->0, then yout=uPC and pop.
//  Push 6 times (STACK_DEPTH=5) -> full_n=0 after the 5th push; the 6th push overwrites the top entry; CRTN returns the 6th address.
//  RPCT with rld_n=0, D=7 and R=3 -> R=7 after the edge (load wins); yout=D.
//  Reset asserted after 3 pushes -> SP=0, full_n=1, yout=0; a following CRTN pass leaves yout=TOS=0.
//  map_n=0 only on JMAP and vect_n=0 only on CJV; pl_n=0 for all other opcodes.

Source files
------------

// File: rtl/am2910_sequencer.sv
// am2910_sequencer: Am2910-style microprogram sequencer.
// Produces the next control-store address (yout) each cycle from the opcode,
// the condition input, the microPC, the loop/count register R and a LIFO
// return stack. yout is combinational; all state moves on the next posedge.
module am2910_sequencer #(
  parameter int AW          = 12,
  parameter int STACK_DEPTH = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    instr,
  input  logic [AW-1:0] din,
  input  logic          cc_n,
  input  logic          ccen_n,
  input  logic          rld_n,
  input  logic          ci,
  output logic [AW-1:0] yout,
  output logic          full_n,
  output logic          pl_n,
  output logic          map_n,
  output logic          vect_n
);

  localparam int             SPW     = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  typedef enum logic [3:0] {
    JZ   = 4'd0,  CJS  = 4'd1,  JMAP = 4'd2,  CJP  = 4'd3,
    PUSH = 4'd4,  JSRP = 4'd5,  CJV  = 4'd6,  JRP  = 4'd7,
    RFCT = 4'd8,  RPCT = 4'd9,  CRTN = 4'd10, CJPP = 4'd11,
    LDCT = 4'd12, LOOP = 4'd13, CONT = 4'd14, TWB  = 4'd15
  } op_t;

  logic [AW-1:0]                  upc;
  logic [AW-1:0]                  r;
  logic [SPW-1:0]                 sp;
  logic [STACK_DEPTH-1:0][AW-1:0] stack;

  logic           pass, rnz;
  logic [AW-1:0]  tos, y_nxt;
  logic           do_push, do_pop, do_clr, r_ld, r_dec;
  logic [SPW-1:0] wr_ptr;

  assign pass = ccen_n | ~cc_n;
  assign rnz  = |r;
  // An empty stack reads as address 0.
  assign tos  = (sp == '0) ? '0 : stack[sp - SPW'(1)];

  // Opcode decode: next address plus the stack / R side effects it implies.
  always_comb begin
    y_nxt   = upc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_clr  = 1'b0;
    r_ld    = 1'b0;
    r_dec   = 1'b0;
    case (op_t'(instr))
      JZ:   begin y_nxt = '0; do_clr = 1'b1; end
      CJS:  begin y_nxt = pass ? din : upc; do_push = pass; end
      JMAP: y_nxt = din;
      CJP:  y_nxt = pass ? din : upc;
      PUSH: begin y_nxt = upc; do_push = 1'b1; r_ld = pass; end
      JSRP: begin y_nxt = pass ? din : r; do_push = 1'b1; end
      CJV:  y_nxt = pass ? din : upc;
      JRP:  y_nxt = pass ? din : r;
      RFCT: begin y_nxt = rnz ? tos : upc; r_dec = rnz; do_pop = ~rnz; end
      RPCT: begin y_nxt = rnz ? din : upc; r_dec = rnz; end
      CRTN: begin y_nxt = pass ? tos : upc; do_pop = pass; end
      CJPP: begin y_nxt = pass ? din : upc; do_pop = pass; end
      LDCT: begin y_nxt = upc; r_ld = 1'b1; end
      LOOP: begin y_nxt = pass ? upc : tos; do_pop = pass; end
      CONT: y_nxt = upc;
      TWB: begin
        if (rnz) begin
          y_nxt  = pass ? upc : tos;
          r_dec  = 1'b1;
          do_pop = pass;
        end else begin
          y_nxt  = pass ? upc : din;
          do_pop = 1'b1;
        end
      end
      default: y_nxt = upc;
    endcase
  end

  // A push onto a full stack overwrites the top entry instead of growing.
  assign wr_ptr = (sp == SP_FULL) ? SP_FULL - SPW'(1) : sp;

  assign yout   = reset ? '0 : y_nxt;
  assign full_n = reset | (sp != SP_FULL);
  assign map_n  = reset | (instr != JMAP);
  assign vect_n = reset | (instr != CJV);
  assign pl_n   = ~reset & ((instr == JMAP) | (instr == CJV));

  // State update: microPC increment, R load/decrement, stack push/pop/clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      upc   <= '0;
      r     <= '0;
      sp    <= '0;
      stack <= '0;
    end else begin
      upc <= yout + AW'(ci);

      // An external load of R takes priority over anything the opcode wants.
      if (!rld_n)     r <= din;
      else if (r_ld)  r <= din;
      else if (r_dec) r <= r - AW'(1);

      if (do_clr) begin
        sp <= '0;
      end else if (do_push) begin
        stack[wr_ptr] <= upc;
        if (sp != SP_FULL) sp <= sp + SPW'(1);
      end else if (do_pop && sp != '0) begin
        sp <= sp - SPW'(1);
      end
    end
  end

endmodule

// File: tb/tb_am2910_sequencer.sv
// tb_am2910_sequencer: scenario tasks drive step tables; the expected yout of
// each step is queued when driven and popped/compared at the following negedge.
module tb_am2910_sequencer;

  localparam logic [3:0] JZ = 4'd0, CJS = 4'd1, JMAP = 4'd2, CJP = 4'd3,
    PUSH = 4'd4, JSRP = 4'd5, CJV = 4'd6, JRP = 4'd7, RFCT = 4'd8,
    RPCT = 4'd9, CRTN = 4'd10, CJPP = 4'd11, LDCT = 4'd12, LOOP = 4'd13,
    CONT = 4'd14, TWB = 4'd15;

  // condition modes: fail, pass via cc_n, pass forced via ccen_n
  localparam logic [1:0] FL = 2'd0, PS = 2'd1, FP = 2'd2;

  typedef struct packed {
    logic [3:0]  i;
    logic [11:0] d;
    logic [1:0]  p;
    logic        c;
    logic        rl;
    logic [11:0] y;
  } step_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  instr;
  logic [11:0] din;
  logic        cc_n, ccen_n, rld_n, ci;
  logic [11:0] yout;
  logic        full_n, pl_n, map_n, vect_n;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [11:0] exp_q[$];

  always #5 clock = ~clock;

  am2910_sequencer #(.AW(12), .STACK_DEPTH(5)) dut (
    .clock(clock), .reset(reset), .instr(instr), .din(din),
    .cc_n(cc_n), .ccen_n(ccen_n), .rld_n(rld_n), .ci(ci),
    .yout(yout), .full_n(full_n), .pl_n(pl_n), .map_n(map_n), .vect_n(vect_n)
  );

  function automatic step_t st(input logic [3:0] i, input logic [11:0] d,
                               input logic [1:0] p, input logic [11:0] y);
    step_t s;
    s.i = i; s.d = d; s.p = p; s.c = 1'b1; s.rl = 1'b1; s.y = y;
    return s;
  endfunction

  task automatic drive(input step_t s);
    instr  = s.i;
    din    = s.d;
    ci     = s.c;
    rld_n  = s.rl;
    ccen_n = (s.p == FP) ? 1'b1 : 1'b0;
    cc_n   = (s.p == PS) ? 1'b0 : 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(st(CONT, 12'h000, FL, 12'h000));
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    reset = 1'b1;
    drive(st(JMAP, 12'h555, PS, 12'h000));
    exp_q.push_back(12'h000);
    @(negedge clock);
    e = exp_q.pop_front();
    n_cmp += 5;
    if (yout !== e)     begin n_bad++; $display("FAIL reset_yout got=%h exp=%h", yout, e); end
    if (full_n !== 1'b1) begin n_bad++; $display("FAIL reset_full_n got=%b exp=1", full_n); end
    if (pl_n !== 1'b0)   begin n_bad++; $display("FAIL reset_pl_n got=%b exp=0", pl_n); end
    if (map_n !== 1'b1)  begin n_bad++; $display("FAIL reset_map_n got=%b exp=1", map_n); end
    if (vect_n !== 1'b1) begin n_bad++; $display("FAIL reset_vect_n got=%b exp=1", vect_n); end
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_cont();
    step_t seq[$];
    logic [11:0] e;
    do_reset();
    for (int k = 0; k < 4; k++) seq.push_back(st(CONT, 12'hABC, FL, 12'(k)));
    foreach (seq[k]) begin
      drive(seq[k]); exp_q.push_back(seq[k].y);
      @(negedge clock); e = exp_q.pop_front(); n_cmp++;
      if (yout !== e) begin n_bad++; $display("FAIL cont[%0d] got=%h exp=%h", k, yout, e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_cjs_crtn();
    step_t seq[$];
    step_t s;
    logic [11:0] e;
    do_reset();
    s = st(CJP, 12'h010, PS, 12'h010); s.c = 1'b0; seq.push_back(s);
    seq.push_back(st(CJS,  12'h100, PS, 12'h100));
    seq.push_back(st(CRTN, 12'h000, PS, 12'h010));
    seq.push_back(st(CRTN, 12'h000, PS, 12'h000));
    foreach (seq[k]) begin
      drive(seq[k]); exp_q.push_back(seq[k].y);
      @(negedge clock); e = exp_q.pop_front(); n_cmp++;
      if (yout !== e) begin n_bad++; $display("FAIL cjs_crtn[%0d] got=%h exp=%h", k, yout, e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_cjp();
    step_t seq[$];
    logic [11:0] e;
    do_reset();
    seq.push_back(st(CJP,  12'h200, FL, 12'h000));
    seq.push_back(st(CJP,  12'h200, FP, 12'h200));
    seq.push_back(st(CONT, 12'h000, FL, 12'h201));
    foreach (seq[k]) begin
      drive(seq[k]); exp_q.push_back(seq[k].y);
      @(negedge clock); e = exp_q.pop_front(); n_cmp++;
      if (yout !== e) begin n_bad++; $display("FAIL cjp[%0d] got=%h exp=%h", k, yout, e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_loop();
    step_t seq[$];
    logic [11:0] e;
    do_reset();
    seq.push_back(st(LDCT, 12'h002, PS, 12'h000));
    seq.push_back(st(CJP,  12'h020, PS, 12'h020));
    seq.push_back(st(PUSH, 12'h3FF, FL, 12'h021));
    seq.push_back(st(RFCT, 12'h000, FL, 12'h021));
    seq.push_back(st(RFCT, 12'h000, FL, 12'h021));
    seq.push_back(st(RFCT, 12'h000, FL, 12'h022));
    seq.push_back(st(CRTN, 12'h000, PS, 12'h000));
    foreach (seq[k]) begin
      drive(seq[k]); exp_q.push_back(seq[k].y);
      @(negedge clock); e = exp_q.pop_front(); n_cmp++;
      if (yout !== e) begin n_bad++; $display("FAIL loop[%0d] got=%h exp=%h", k, yout, e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_stack_full();
    step_t seq[$];
    logic [11:0] e;
    logic        ef;
    do_reset();
    for (int k = 0; k < 6; k++) seq.push_back(st(PUSH, 12'h000, FL, 12'(k)));
    seq.push_back(st(CRTN, 12'h000, PS, 12'h005));
    seq.push_back(st(CRTN, 12'h000, PS, 12'h003));
    foreach (seq[k]) begin
      drive(seq[k]); exp_q.push_back(seq[k].y);
      ef = (k == 5 || k == 6) ? 1'b0 : 1'b1;
      @(negedge clock); e = exp_q.pop_front(); n_cmp += 2;
      if (yout !== e) begin n_bad++; $display("FAIL stack_full_y[%0d] got=%h exp=%h", k, yout, e); end
      if (full_n !== ef) begin n_bad++; $display("FAIL stack_full_n[%0d] got=%b exp=%b", k, full_n, ef); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_rld();
    step_t seq[$];
    step_t s;
    logic [11:0] e;
    do_reset();
    seq.push_back(st(LDCT, 12'h003, PS, 12'h000));
    s = st(RPCT, 12'h007, PS, 12'h007); s.rl = 1'b0; seq.push_back(s);
    for (int k = 0; k < 8; k++)
      seq.push_back(st(RPCT, 12'h300, PS, (k < 7) ? 12'h300 : 12'h301));
    foreach (seq[k]) begin
      drive(seq[k]); exp_q.push_back(seq[k].y);
      @(negedge clock); e = exp_q.pop_front(); n_cmp++;
      if (yout !== e) begin n_bad++; $display("FAIL rld[%0d] got=%h exp=%h", k, yout, e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid();
    step_t seq[$];
    logic [11:0] e;
    do_reset();
    seq.push_back(st(LDCT, 12'h005, PS, 12'h000));
    for (int k = 1; k <= 3; k++) seq.push_back(st(PUSH, 12'h000, FL, 12'(k)));
    foreach (seq[k]) begin
      drive(seq[k]); exp_q.push_back(seq[k].y);
      @(negedge clock); e = exp_q.pop_front(); n_cmp++;
      if (yout !== e) begin n_bad++; $display("FAIL mid_pre[%0d] got=%h exp=%h", k, yout, e); end
      @(posedge clock); #1;
    end
    reset = 1'b1;
    drive(st(CRTN, 12'h000, PS, 12'h000));
    exp_q.push_back(12'h000);
    @(negedge clock); e = exp_q.pop_front(); n_cmp += 2;
    if (yout !== e)      begin n_bad++; $display("FAIL mid_rst_y got=%h exp=%h", yout, e); end
    if (full_n !== 1'b1) begin n_bad++; $display("FAIL mid_rst_full_n got=%b exp=1", full_n); end
    @(posedge clock);
    #1 reset = 1'b0;
    seq = {};
    seq.push_back(st(CRTN, 12'h000, PS, 12'h000));
    seq.push_back(st(RPCT, 12'h123, PS, 12'h001));
    foreach (seq[k]) begin
      drive(seq[k]); exp_q.push_back(seq[k].y);
      @(negedge clock); e = exp_q.pop_front(); n_cmp++;
      if (yout !== e) begin n_bad++; $display("FAIL mid_post[%0d] got=%h exp=%h", k, yout, e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_select();
    logic ep, em, ev;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(st(4'(k), 12'h000, FL, 12'h000));
      em = (k != 2);
      ev = (k != 6);
      ep = (k == 2 || k == 6);
      @(negedge clock); n_cmp += 3;
      if (pl_n !== ep)   begin n_bad++; $display("FAIL sel_pl_n[%0d] got=%b exp=%b", k, pl_n, ep); end
      if (map_n !== em)  begin n_bad++; $display("FAIL sel_map_n[%0d] got=%b exp=%b", k, map_n, em); end
      if (vect_n !== ev) begin n_bad++; $display("FAIL sel_vect_n[%0d] got=%b exp=%b", k, vect_n, ev); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_misc();
    step_t seq[$];
    logic [11:0] e;
    do_reset();
    seq.push_back(st(LDCT, 12'h050, PS, 12'h000));
    seq.push_back(st(JSRP, 12'h0EE, FL, 12'h050));
    seq.push_back(st(JRP,  12'h070, PS, 12'h070));
    seq.push_back(st(JRP,  12'h070, FL, 12'h050));
    seq.push_back(st(CJPP, 12'h080, PS, 12'h080));
    seq.push_back(st(CRTN, 12'h000, PS, 12'h000));
    seq.push_back(st(CJV,  12'h090, FL, 12'h001));
    seq.push_back(st(CJV,  12'h090, PS, 12'h090));
    seq.push_back(st(JMAP, 12'hFFF, FL, 12'hFFF));
    seq.push_back(st(CONT, 12'h000, FL, 12'h000));
    seq.push_back(st(PUSH, 12'h000, FL, 12'h001));
    seq.push_back(st(JZ,   12'h000, FL, 12'h000));
    seq.push_back(st(CRTN, 12'h000, PS, 12'h000));
    seq.push_back(st(CJS,  12'h0AA, FL, 12'h001));
    seq.push_back(st(CRTN, 12'h000, PS, 12'h000));
    foreach (seq[k]) begin
      drive(seq[k]); exp_q.push_back(seq[k].y);
      @(negedge clock); e = exp_q.pop_front(); n_cmp++;
      if (yout !== e) begin n_bad++; $display("FAIL misc[%0d] got=%h exp=%h", k, yout, e); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_twb_loop();
    step_t seq[$];
    logic [11:0] e;
    do_reset();
    seq.push_back(st(LDCT, 12'h001, PS, 12'h000));
    seq.push_back(st(PUSH, 12'h000, FL, 12'h001));
    seq.push_back(st(TWB,  12'h0C0, FL, 12'h001));
    seq.push_back(st(TWB,  12'h0C0, FL, 12'h0C0));
    seq.push_back(st(CRTN, 12'h000, PS, 12'h000));
    seq.push_back(st(PUSH, 12'h000, FL, 12'h001));
    seq.push_back(st(LOOP, 12'h000, FL, 12'h001));
    seq.push_back(st(LOOP, 12'h000, PS, 12'h002));
    seq.push_back(st(CRTN, 12'h000, PS, 12'h000));
    seq.push_back(st(PUSH, 12'h000, FL, 12'h001));
    seq.push_back(st(TWB,  12'h0C0, PS, 12'h002));
    seq.push_back(st(CRTN, 12'h000, PS, 12'h000));
    foreach (seq[k]) begin
      drive(seq[k]); exp_q.push_back(seq[k].y);
      @(negedge clock); e = exp_q.pop_front(); n_cmp++;
      if (yout !== e) begin n_bad++; $display("FAIL twb_loop[%0d] got=%h exp=%h", k, yout, e); end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(st(CONT, 12'h000, FL, 12'h000));
    test_reset();
    test_cont();
    test_cjs_crtn();
    test_cjp();
    test_loop();
    test_stack_full();
    test_rld();
    test_reset_mid();
    test_select();
    test_misc();
    test_twb_loop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
